// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the fetch front-end and the decoder.
package riscv_pkg;
   localparam int          XLEN        = 32;
   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   localparam logic [6:0]  R_TYPE = 7'b0110011;
   localparam logic [6:0]  I_TYPE = 7'b0010011;
   localparam logic [6:0]  LOAD   = 7'b0000011;
   localparam logic [6:0]  STORE  = 7'b0100011;
   localparam logic [6:0]  BRANCH = 7'b1100011;
   localparam logic [6:0]  JAL    = 7'b1101111;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // Clear the byte-offset bits so the address points at a whole instruction word.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(INSTR_BYTES - 1);
   endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and decoder output.
interface instr_fetch_unit_if;
   import riscv_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Registered synchronous FIFO with flush; read data is the head entry (no write-through bypass).
module fetch_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Status flags and guarded push/pop strobes.
   always_comb begin
      full      = (count_r == CW'(DEPTH));
      empty     = (count_r == CW'(0));
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
      rdata     = mem_r[rd_ptr_r];
      count     = count_r;
   end

   // Pointer and occupancy update; flush empties the buffer outright.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= CW'(0);
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (push_ok_s && !flush && !rst) mem_r[wr_ptr_r] <= wdata;
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, stale-response dropping on redirect,
// and a buffered instruction stream toward the decoder.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   instr_fetch_unit_if.master fetch
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 2;

   logic [XLEN-1:0] pc_r, pc_s;
   logic [CW-1:0]   outstanding_r, outstanding_s;
   logic [CW-1:0]   drop_cnt_r, drop_cnt_s;
   logic            credit_s, req_valid_s, accept_s;
   logic            rsp_drop_s, rsp_take_s;
   logic            fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
   logic [CW-1:0]   fifo_count_s;
   fetch_entry_t    fifo_wdata_s, fifo_rdata_s;

   // Request credit, response classification and next-state for PC and counters.
   always_comb begin
      credit_s    = (SW'(outstanding_r) + SW'(fifo_count_s) + SW'(drop_cnt_r)) < SW'(FIFO_DEPTH);
      req_valid_s = !rst && !fetch.redirect_valid && credit_s;
      accept_s    = req_valid_s && fetch.imem_req_ready;
      rsp_drop_s  = fetch.imem_rsp_valid && (drop_cnt_r != CW'(0));
      rsp_take_s  = fetch.imem_rsp_valid && (drop_cnt_r == CW'(0)) && (outstanding_r != CW'(0));
      fifo_push_s = rsp_take_s && !fetch.redirect_valid && !fifo_full_s;
      fifo_pop_s  = !fifo_empty_s && fetch.inst_ready && !fetch.redirect_valid;
      // Requests are consecutive since the last redirect, so the oldest in-flight one is this far back.
      fifo_wdata_s.inst = fetch.imem_rsp_data;
      fifo_wdata_s.pc   = pc_r - (XLEN'(outstanding_r) << 2);
      if (fetch.redirect_valid) begin
         pc_s          = word_align(fetch.redirect_pc);
         outstanding_s = CW'(0);
         drop_cnt_s    = drop_cnt_r + outstanding_r - CW'(rsp_drop_s || rsp_take_s);
      end else begin
         pc_s          = accept_s ? pc_r + XLEN'(INSTR_BYTES) : pc_r;
         outstanding_s = outstanding_r + CW'(accept_s) - CW'(rsp_take_s);
         drop_cnt_s    = drop_cnt_r - CW'(rsp_drop_s);
      end
   end

   // PC and in-flight bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r          <= RESET_PC;
         outstanding_r <= CW'(0);
         drop_cnt_r    <= CW'(0);
      end else begin
         pc_r          <= pc_s;
         outstanding_r <= outstanding_s;
         drop_cnt_r    <= drop_cnt_s;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push_s),
      .wdata (fifo_wdata_s),
      .pop   (fifo_pop_s),
      .flush (fetch.redirect_valid),
      .rdata (fifo_rdata_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Bus outputs; the decoder sees a NOP whenever nothing is buffered.
   always_comb begin
      fetch.imem_req_valid = req_valid_s;
      fetch.imem_req_addr  = pc_r;
      fetch.inst_valid     = !fifo_empty_s;
      if (fifo_empty_s) begin
         fetch.inst    = NOP_INSTR;
         fetch.inst_pc = XLEN'(0);
      end else begin
         fetch.inst    = fifo_rdata_s.inst;
         fetch.inst_pc = fifo_rdata_s.pc;
      end
   end
endmodule
